// File: rtl/pc_predict.sv
// pc_predict: fetch-stage program counter with a direct-mapped BTB and
// saturating-counter direction prediction.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   pcEN            fetch advance enable (0 holds the PC)
//   imemaddr, npc   registered fetch PC and PC+4
//   pred_taken      current fetch is a BTB hit with a taken-leaning counter
//   pred_target     predicted next PC (npc when not predicted taken)
//   ex_redirect,    execute-stage correction, wins over stall and prediction
//   ex_correct_pc
//   ex_update,      training report from branch resolution
//   ex_pc, ex_taken,
//   ex_target

// One BTB entry: owns its valid/tag/target/counter and applies the training
// rule when the shared update port selects it.
module pc_predict_btb_entry #(
  parameter int TAG_W = 26,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,       // ex_update addressed to this index
  input  logic [TAG_W-1:0] ex_tag,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      target,
  output logic [CTR_W-1:0] ctr
);
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W-1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic upd_hit;
  assign upd_hit = valid && (tag == ex_tag);

  // Only valid is reset; the payload is meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (sel) begin
      if (upd_hit) begin
        if (ex_taken) begin
          if (ctr != CTR_MAX) ctr <= ctr + CTR_W'(1);
          target <= ex_target;
        end else begin
          if (ctr != '0) ctr <= ctr - CTR_W'(1);
        end
      end else if (ex_taken) begin
        // Allocate or replace an aliasing entry, starting weakly taken.
        valid  <= 1'b1;
        tag    <= ex_tag;
        target <= ex_target;
        ctr    <= CTR_WEAK;
      end
    end
  end
endmodule

module pc_predict #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          BTB_DEPTH = 16,
  parameter int          CTR_W     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pcEN,
  output logic [31:0] imemaddr,
  output logic [31:0] npc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_correct_pc,
  input  logic        ex_update,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_DEPTH-1:0]            e_valid;
  logic [BTB_DEPTH-1:0][TAG_W-1:0] e_tag;
  logic [BTB_DEPTH-1:0][31:0]      e_target;
  logic [BTB_DEPTH-1:0][CTR_W-1:0] e_ctr;
  logic [BTB_DEPTH-1:0]            e_sel;

  logic [IDX_W-1:0] ex_idx, lk_idx;
  logic [TAG_W-1:0] ex_tag, lk_tag;
  logic             lk_hit;
  logic [31:0]      pc;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_lowbits;
  assign unused_lowbits = ^{ex_pc[1:0], pc[1:0]};

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign lk_idx = pc[IDX_W+1:2];
  assign lk_tag = pc[31:IDX_W+2];

  for (genvar i = 0; i < BTB_DEPTH; i++) begin : g_btb
    assign e_sel[i] = ex_update && (ex_idx == IDX_W'(i));
    pc_predict_btb_entry #(.TAG_W(TAG_W), .CTR_W(CTR_W)) u_ent (
      .clk      (CLK),
      .rst      (RST),
      .sel      (e_sel[i]),
      .ex_tag   (ex_tag),
      .ex_taken (ex_taken),
      .ex_target(ex_target),
      .valid    (e_valid[i]),
      .tag      (e_tag[i]),
      .target   (e_target[i]),
      .ctr      (e_ctr[i])
    );
  end

  // Lookup sees registered BTB state, so a same-cycle write is not visible.
  assign lk_hit      = e_valid[lk_idx] && (e_tag[lk_idx] == lk_tag);
  assign npc         = pc + 32'd4;
  assign pred_taken  = lk_hit && e_ctr[lk_idx][CTR_W-1];
  assign pred_target = pred_taken ? e_target[lk_idx] : npc;
  assign imemaddr    = pc;

  // Redirect beats stall; pred_target already folds in the npc fallback.
  always_ff @(posedge CLK) begin
    if (RST)              pc <= PC_RESET;
    else if (ex_redirect) pc <= ex_correct_pc;
    else if (pcEN)        pc <= pred_target;
  end
endmodule

// File: tb/tb_pc_predict.sv
module tb_pc_predict;
  logic        CLK = 1'b0;
  logic        RST, pcEN, ex_redirect, ex_update, ex_taken;
  logic [31:0] ex_correct_pc, ex_pc, ex_target;
  logic [31:0] imemaddr, npc, pred_target;
  logic        pred_taken;

  int errors = 0;
  int checks = 0;

  pc_predict #(.PC_RESET(32'h0000_0040), .BTB_DEPTH(16), .CTR_W(2)) dut (
    .CLK(CLK), .RST(RST), .pcEN(pcEN),
    .imemaddr(imemaddr), .npc(npc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_redirect(ex_redirect), .ex_correct_pc(ex_correct_pc),
    .ex_update(ex_update), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Park fetch on pc without advancing (pcEN low, one redirect cycle).
  task automatic park(input logic [31:0] pc);
    pcEN = 1'b0; ex_redirect = 1'b1; ex_correct_pc = pc;
    tick();
    ex_redirect = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    ex_update = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    tick();
    ex_update = 1'b0;
  endtask

  initial begin
    RST = 1'b1; pcEN = 1'b0; ex_redirect = 1'b0; ex_update = 1'b0; ex_taken = 1'b0;
    ex_correct_pc = '0; ex_pc = '0; ex_target = '0;
    tick(); tick();
    chk("rst_pc", imemaddr, 32'h40);
    chk("rst_npc", npc, 32'h44);
    chk("rst_pt", {31'b0, pred_taken}, 32'h0);
    chk("rst_ptgt", pred_target, 32'h44);

    RST = 1'b0; pcEN = 1'b1;
    tick(); chk("seq1", imemaddr, 32'h44);
    tick(); chk("seq2", imemaddr, 32'h48);
    chk("seq2_pt", {31'b0, pred_taken}, 32'h0);
    tick(); chk("seq3", imemaddr, 32'h4C);

    // Train 0x50 taken while fetch steps 0x4C -> 0x50.
    ex_update = 1'b1; ex_pc = 32'h50; ex_taken = 1'b1; ex_target = 32'h100;
    tick(); ex_update = 1'b0;
    chk("alloc_pc", imemaddr, 32'h50);
    chk("alloc_pt", {31'b0, pred_taken}, 32'h1);
    chk("alloc_tgt", pred_target, 32'h100);
    tick(); chk("follow_pred", imemaddr, 32'h100);

    // Counter: 2 -> 3 -> saturate, then walk down.
    park(32'h50);
    chk("park50", imemaddr, 32'h50);
    train(32'h50, 1'b1, 32'h100);
    train(32'h50, 1'b1, 32'h100);
    train(32'h50, 1'b1, 32'h100);
    chk("ctr3_pt", {31'b0, pred_taken}, 32'h1);
    train(32'h50, 1'b0, 32'h0);
    chk("ctr2_pt", {31'b0, pred_taken}, 32'h1);
    train(32'h50, 1'b0, 32'h0);
    chk("ctr1_pt", {31'b0, pred_taken}, 32'h0);
    chk("ctr1_tgt", pred_target, 32'h54);
    pcEN = 1'b1;
    tick(); chk("ctr1_next", imemaddr, 32'h54);
    park(32'h50);
    train(32'h50, 1'b0, 32'h0);
    train(32'h50, 1'b0, 32'h0);
    train(32'h50, 1'b1, 32'h100);
    chk("no_underflow", {31'b0, pred_taken}, 32'h0);
    train(32'h50, 1'b1, 32'h100);
    chk("ctr2_again", {31'b0, pred_taken}, 32'h1);
    chk("ctr2_tgt", pred_target, 32'h100);
    train(32'h50, 1'b1, 32'h180);
    chk("tgt_overwrite", pred_target, 32'h180);

    // Aliasing: 0x90 shares index 4 with 0x50.
    park(32'h90);
    chk("alias_miss", {31'b0, pred_taken}, 32'h0);
    chk("alias_tgt", pred_target, 32'h94);
    train(32'h90, 1'b1, 32'h300);
    chk("alias_alloc", pred_target, 32'h300);
    park(32'h50);
    chk("evicted50", {31'b0, pred_taken}, 32'h0);

    // Redirect beats stall and a taken prediction.
    park(32'h90);
    chk("prio_hit", {31'b0, pred_taken}, 32'h1);
    ex_redirect = 1'b1; ex_correct_pc = 32'h200;
    tick(); ex_redirect = 1'b0;
    chk("prio_redir", imemaddr, 32'h200);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_pc", imemaddr, 32'h200);
      chk("hold_npc", npc, 32'h204);
    end

    // Address wrap.
    park(32'hFFFF_FFFC);
    chk("wrap_npc", npc, 32'h0);
    pcEN = 1'b1;
    tick(); chk("wrap_pc", imemaddr, 32'h0);

    // Reset with a simultaneous taken update drops the update.
    RST = 1'b1; ex_update = 1'b1; ex_pc = 32'h60; ex_taken = 1'b1; ex_target = 32'h400;
    tick();
    RST = 1'b0; ex_update = 1'b0;
    chk("rst2_pc", imemaddr, 32'h40);
    park(32'h60);
    chk("rst2_60", {31'b0, pred_taken}, 32'h0);
    park(32'h90);
    chk("rst2_90", {31'b0, pred_taken}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
